crop_run_scheduler: RTL and testbench

- Sequences back-to-back runs of the crop_plus_gaussian core over an ap_ctrl_hs-style start/ready/done handshake.
- Accepts crop-window requests (row/col origin) on a stream interface and queues them in a small FIFO.
- For each request it range-checks the window, drives the crop origin, starts the core, and times the run against a watchdog.
- Emits one status beat per request; sits between the host/config stream and the core's control port.

---
 rtl/crop_run_scheduler.sv | 112 +++++++++++
 tb/tb_crop_run_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/crop_run_scheduler.sv
// crop_run_scheduler: queues crop requests (req_*), sequences core runs via ap_ctrl_hs (core_*), reports status (stat_*), busy/pending
module crop_run_scheduler #(
  parameter int IN_ROWS = 100,
  parameter int IN_COLS = 160,
  parameter int OUT_ROWS = 48,
  parameter int OUT_COLS = 48,
  parameter int COORD_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CYC_W = 24,
  parameter int ID_W = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [2*COORD_W-1:0]          req_TDATA,
  input  logic                          req_TVALID,
  output logic                          req_TREADY,
  output logic [COORD_W-1:0]            core_y1,
  output logic [COORD_W-1:0]            core_x1,
  output logic                          core_start,
  input  logic                          core_ready,
  input  logic                          core_done,
  input  logic                          core_idle,
  output logic [2+ID_W+CYC_W-1:0]       stat_TDATA,
  output logic                          stat_TVALID,
  input  logic                          stat_TREADY,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   pending
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, REPORT} state_t;
  state_t r_state;
  logic [2*COORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wp, r_rp, w_cnt;
  logic [COORD_W-1:0] r_y1, r_x1;
  logic [CYC_W-1:0] r_cyc, w_cyc_nx;
  logic [ID_W-1:0] r_id;
  logic [2+ID_W+CYC_W-1:0] r_stat;
  logic r_start, r_stat_valid, w_push, w_pop, w_ok;
  assign w_cnt = r_wp - r_rp;
  assign req_TREADY = w_cnt != (AW+1)'(FIFO_DEPTH);
  assign w_push = req_TVALID && req_TREADY;
  assign w_pop = (r_state == IDLE) && (w_cnt != '0) && core_idle;
  assign w_ok = (({1'b0, r_y1} + (COORD_W+1)'(OUT_ROWS)) <= (COORD_W+1)'(IN_ROWS)) &&
                (({1'b0, r_x1} + (COORD_W+1)'(OUT_COLS)) <= (COORD_W+1)'(IN_COLS));
  assign w_cyc_nx = r_cyc + 1'b1;
  assign core_y1 = r_y1;
  assign core_x1 = r_x1;
  assign core_start = r_start;
  assign stat_TDATA = r_stat;
  assign stat_TVALID = r_stat_valid;
  assign busy = r_state != IDLE;
  assign pending = w_cnt;
  always_ff @(posedge ap_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= req_TDATA;
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_wp <= '0;
      r_rp <= '0;
      r_y1 <= '0;
      r_x1 <= '0;
      r_cyc <= '0;
      r_id <= '0;
      r_stat <= '0;
      r_start <= 1'b0;
      r_stat_valid <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case (r_state)
        IDLE: if (w_pop) begin
          {r_y1, r_x1} <= r_mem[r_rp[AW-1:0]];
          r_state <= LOAD;
        end
        LOAD: if (w_ok) begin
          r_cyc <= '0;
          r_start <= 1'b1;
          r_state <= START;
        end else begin
          r_stat <= {2'b10, r_id, {CYC_W{1'b0}}};
          r_stat_valid <= 1'b1;
          r_state <= REPORT;
        end
        START, WAIT: if (core_done && (r_state == WAIT || core_ready)) begin
          r_stat <= {2'b00, r_id, w_cyc_nx};
          r_stat_valid <= 1'b1;
          r_start <= 1'b0;
          r_state <= REPORT;
        end else if (w_cyc_nx >= CYC_W'(TIMEOUT_CYCLES)) begin
          r_stat <= {2'b01, r_id, CYC_W'(TIMEOUT_CYCLES)};
          r_stat_valid <= 1'b1;
          r_start <= 1'b0;
          r_state <= REPORT;
        end else begin
          r_cyc <= w_cyc_nx;
          if (r_state == START && core_ready) begin
            r_start <= 1'b0;
            r_state <= WAIT;
          end
        end
        REPORT: if (stat_TREADY) begin
          r_stat_valid <= 1'b0;
          r_id <= r_id + 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crop_run_scheduler.sv
// tb_crop_run_scheduler: randomized scoreboard bench for crop_run_scheduler
module tb_crop_run_scheduler;
  logic ap_clk = 0, ap_rst = 1;
  logic [15:0] req_TDATA = 0;
  logic req_TVALID = 0, req_TREADY;
  logic [7:0] core_y1, core_x1;
  logic core_start, core_ready, core_done, core_idle = 1;
  logic [33:0] stat_TDATA;
  logic stat_TVALID, stat_TREADY = 1;
  logic busy;
  logic [2:0] pending;
  logic m_ready = 0, m_done = 0, stray_done = 0;
  int rdy_dly = 0, dn_dly = 50, tr_mode = 0;
  int n_chk = 0, n_fail = 0, n_starts = 0, n_start_cyc = 0;
  logic [33:0] exp_q[$];
  logic [15:0] coord_q[$];
  logic [15:0] cur = 0;
  logic [7:0] mid = 0;
  bit run = 0;
  int k = 0;
  logic prev_s = 0, mon_prev = 0;
  assign core_ready = m_ready;
  assign core_done = m_done | stray_done;
  crop_run_scheduler #(.TIMEOUT_CYCLES(100)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_TDATA(req_TDATA), .req_TVALID(req_TVALID), .req_TREADY(req_TREADY),
    .core_y1(core_y1), .core_x1(core_x1), .core_start(core_start),
    .core_ready(core_ready), .core_done(core_done), .core_idle(core_idle),
    .stat_TDATA(stat_TDATA), .stat_TVALID(stat_TVALID), .stat_TREADY(stat_TREADY),
    .busy(busy), .pending(pending)
  );
  always #5 ap_clk = ~ap_clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [33:0] mk(input bit er, input bit et, input logic [7:0] id, input int c);
    logic [23:0] cc;
    cc = c[23:0];
    return {er, et, id, cc};
  endfunction
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask
  // core: ready rdy_dly cycles into start, single done pulse dn_dly cycles after first start cycle
  always @(posedge ap_clk) begin
    #1;
    if (core_start && !prev_s) begin
      run = 1;
      k = 0;
    end
    m_ready = core_start && run && k >= rdy_dly;
    m_done = run && k == dn_dly;
    if (m_done) run = 0;
    prev_s = core_start;
    if (run) k++;
  end
  always @(posedge ap_clk) begin
    #1;
    stat_TREADY = (tr_mode == 0) ? 1'b1 : (tr_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b0;
  end
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (core_start && !mon_prev) begin
        if (coord_q.size() != 0) cur = coord_q.pop_front();
        n_starts++;
      end
      mon_prev = core_start;
      if (core_start || (m_done && busy)) begin
        if (core_start) n_start_cyc++;
        chk("core_y1", core_y1, cur[15:8]);
        chk("core_x1", core_x1, cur[7:0]);
      end
      if (stat_TVALID && stat_TREADY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL stat_unexpected: got %0h expected none", stat_TDATA);
        end else chk("stat", stat_TDATA, exp_q.pop_front());
      end
    end else mon_prev = 0;
  end
  task automatic send(input int y, input int x);
    int n = 0;
    if (y + 48 <= 100 && x + 48 <= 160) begin
      coord_q.push_back({y[7:0], x[7:0]});
      if (rdy_dly >= 100 || dn_dly >= 100) exp_q.push_back(mk(0, 1, mid, 100));
      else exp_q.push_back(mk(0, 0, mid, dn_dly + 1));
    end else exp_q.push_back(mk(1, 0, mid, 0));
    mid++;
    tick();
    req_TVALID = 1;
    req_TDATA = {y[7:0], x[7:0]};
    @(negedge ap_clk);
    while (!req_TREADY && n < 1000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("send_bound", n < 1000, 1);
    tick();
    req_TVALID = 0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || busy || pending != 0) && n < lim) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain_bound", n < lim, 1);
  endtask
  task automatic chk_reset();
    chk("rst_treadY", req_TREADY, 1);
    chk("rst_pending", pending, 0);
    chk("rst_start", core_start, 0);
    chk("rst_svalid", stat_TVALID, 0);
    chk("rst_sdata", stat_TDATA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_y1", core_y1, 0);
    chk("rst_x1", core_x1, 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    int s0, c0, n;
    logic [7:0] tid;
    repeat (3) tick();
    ap_rst = 0;
    @(negedge ap_clk);
    chk_reset();
    rdy_dly = 0; dn_dly = 50;
    c0 = n_start_cyc;
    send(10, 10);
    drain(500);
    chk("start_one_cycle", n_start_cyc - c0, 1);
    s0 = n_starts;
    send(60, 10);
    send(10, 113);
    send(52, 112);
    drain(500);
    chk("range_err_starts", n_starts - s0, 1);
    rdy_dly = 2; dn_dly = 30;
    s0 = n_starts;
    tick();
    core_idle = 0;
    for (int i = 0; i < 4; i++) send($urandom_range(0, 52), $urandom_range(0, 112));
    @(negedge ap_clk);
    chk("full_pending", pending, 4);
    chk("full_tready", req_TREADY, 0);
    chk("full_busy", busy, 0);
    fork
      begin
        repeat (6) tick();
        core_idle = 1;
      end
    join_none
    send($urandom_range(0, 52), $urandom_range(0, 112));
    drain(2000);
    chk("fifo_runs", n_starts - s0, 5);
    rdy_dly = 0;
    for (int d = 98; d <= 99; d++) begin
      dn_dly = d;
      send(0, 0);
      drain(500);
    end
    dn_dly = 1000;
    tr_mode = 2;
    tid = mid;
    send(20, 30);
    n = 0;
    while (!stat_TVALID && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    chk("timeout_bound", n < 400, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      stray_done = (i == 5);
      @(negedge ap_clk);
      chk("hold_sdata", stat_TDATA, mk(0, 1, tid, 100));
      chk("hold_svalid", stat_TVALID, 1);
      chk("hold_start", core_start, 0);
      chk("hold_busy", busy, 1);
    end
    tick();
    stray_done = 0;
    tr_mode = 0;
    drain(500);
    chk("to_idle_busy", busy, 0);
    chk("to_idle_start", core_start, 0);
    tr_mode = 1;
    for (int r = 0; r < 6; r++) begin
      rdy_dly = $urandom_range(0, 3);
      dn_dly = rdy_dly + $urandom_range(0, 40);
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) send($urandom_range(0, 70), $urandom_range(0, 130));
      drain(2000);
    end
    tr_mode = 0;
    rdy_dly = 0; dn_dly = 1000;
    for (int i = 0; i < 3; i++) send(5 * i, 7 * i);
    n = 0;
    while (!(pending == 2 && busy && !core_start && !stat_TVALID) && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    chk("wait_reach_bound", n < 200, 1);
    tick();
    ap_rst = 1;
    exp_q.delete();
    coord_q.delete();
    mid = 0;
    tick();
    ap_rst = 0;
    @(negedge ap_clk);
    chk_reset();
    tick();
    stray_done = 1;
    tick();
    stray_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      chk("post_rst_svalid", stat_TVALID, 0);
    end
    rdy_dly = 1; dn_dly = 50;
    send(10, 10);
    drain(500);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
